// File: rtl/matrix_pkg.sv
// Shared definitions for the 5x5 matrix coprocessor blocks (scalar multiply
// and scalar divide): geometry, packing helper and the divider FSM states.
package matrix_pkg;

  localparam int MAT_DIM = 5;
  localparam int ELEM_W  = 8;
  localparam int N_ELEM  = MAT_DIM * MAT_DIM;
  localparam int MAT_W   = N_ELEM * ELEM_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Element idx of a packed matrix lives at bits [idx*ELEM_W +: ELEM_W].
  function automatic logic [ELEM_W-1:0] get_elem(input logic [MAT_W-1:0] mat,
                                                 input int idx);
    return mat[idx*ELEM_W +: ELEM_W];
  endfunction

endpackage

// File: rtl/restoring_div_step.sv
// One combinational step of a restoring divider: shift in the next dividend
// bit and subtract the divisor if it fits. The shifted value carries one
// extra bit so the compare never overflows.
module restoring_div_step #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_rem,
  input  logic         i_dbit,
  input  logic [W-1:0] i_divisor,
  output logic [W-1:0] o_rem,
  output logic         o_qbit
);

  logic [W:0] w_shift;
  logic [W:0] w_diff;
  logic       w_fits;

  assign w_shift = {i_rem, i_dbit};
  assign w_diff  = w_shift - {1'b0, i_divisor};
  assign w_fits  = (w_shift >= {1'b0, i_divisor});

  // Restore (keep the shifted value) when the divisor does not fit; the
  // kept value is then below the divisor and fits back into W bits.
  always_comb begin
    o_qbit = w_fits;
    o_rem  = w_fits ? w_diff[W-1:0] : w_shift[W-1:0];
  end

endmodule

// File: rtl/matrix_scalar_div.sv
// Divides each element of a packed 5x5 unsigned matrix by an unsigned scalar
// using one shared bit-serial restoring divider, one quotient bit per clock,
// elements walked 0..24. A zero divisor short-circuits to an all-ones result.
module matrix_scalar_div
  import matrix_pkg::*;
#(
  parameter int N_ELEM = 25,
  parameter int ELEM_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [ELEM_W-1:0]          data,
  input  logic [N_ELEM*ELEM_W-1:0]   matrix_a,
  output logic [N_ELEM*ELEM_W-1:0]   result,
  output logic                       busy,
  output logic                       done,
  output logic                       div_by_zero,
  output logic [1:0]                 dbg_state
);

  localparam int LP_MAT_W = N_ELEM * ELEM_W;
  localparam int LP_IDX_W = $clog2(N_ELEM);
  localparam int LP_BIT_W = $clog2(ELEM_W);
  localparam logic [LP_IDX_W-1:0] LP_LAST_ELEM = LP_IDX_W'(N_ELEM - 1);
  localparam logic [LP_BIT_W-1:0] LP_LAST_BIT  = LP_BIT_W'(ELEM_W - 1);

  state_t                r_state;
  state_t                w_next_state;
  logic [ELEM_W-1:0]     r_divisor;
  logic [LP_MAT_W-1:0]   r_mat;
  logic [LP_MAT_W-1:0]   r_buf;
  logic [LP_MAT_W-1:0]   r_result;
  logic                  r_dbz;
  logic [LP_IDX_W-1:0]   r_elem;
  logic [LP_BIT_W-1:0]   r_bit;
  logic [ELEM_W-1:0]     r_rem;
  logic [ELEM_W-1:0]     r_q;

  logic [ELEM_W-1:0]     w_cur_elem;
  logic                  w_dbit;
  logic [ELEM_W-1:0]     w_rem_next;
  logic                  w_qbit;
  logic [ELEM_W-1:0]     w_qbyte;
  logic [LP_MAT_W-1:0]   w_buf_upd;
  logic                  w_last_bit;
  logic                  w_last_elem;

  // Dividend bits are consumed MSB first.
  assign w_cur_elem  = r_mat[r_elem*ELEM_W +: ELEM_W];
  assign w_dbit      = w_cur_elem[LP_LAST_BIT - r_bit];
  assign w_qbyte     = {r_q[ELEM_W-2:0], w_qbit};
  assign w_last_bit  = (r_bit == LP_LAST_BIT);
  assign w_last_elem = (r_elem == LP_LAST_ELEM);

  restoring_div_step #(.W(ELEM_W)) u_step (
    .i_rem     (r_rem),
    .i_dbit    (w_dbit),
    .i_divisor (r_divisor),
    .o_rem     (w_rem_next),
    .o_qbit    (w_qbit)
  );

  // Buffer with the quotient of the current element dropped into its slot.
  always_comb begin
    w_buf_upd = r_buf;
    w_buf_upd[r_elem*ELEM_W +: ELEM_W] = w_qbyte;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state and status outputs; DONE always lasts exactly one cycle.
  always_comb begin
    w_next_state = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next_state = (data == '0) ? DONE : DIVIDE;
      end
      DIVIDE: begin
        busy = 1'b1;
        if (w_last_bit && w_last_elem) w_next_state = DONE;
      end
      DONE: begin
        done         = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Operand latch, serial divide datapath and result/flag update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_divisor <= '0;
      r_mat     <= '0;
      r_buf     <= '0;
      r_result  <= '0;
      r_dbz     <= 1'b0;
      r_elem    <= '0;
      r_bit     <= '0;
      r_rem     <= '0;
      r_q       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_divisor <= data;
            r_mat     <= matrix_a;
            r_elem    <= '0;
            r_bit     <= '0;
            r_rem     <= '0;
            r_q       <= '0;
            if (data == '0) begin
              r_result <= '1;
              r_dbz    <= 1'b1;
            end else begin
              r_dbz    <= 1'b0;
            end
          end
        end
        DIVIDE: begin
          if (w_last_bit) begin
            r_buf <= w_buf_upd;
            r_rem <= '0;
            r_q   <= '0;
            r_bit <= '0;
            if (w_last_elem) r_result <= w_buf_upd;
            else             r_elem   <= r_elem + 1'b1;
          end else begin
            r_rem <= w_rem_next;
            r_q   <= w_qbyte;
            r_bit <= r_bit + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign result      = r_result;
  assign div_by_zero = r_dbz;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_matrix_scalar_div.sv
// Bench for matrix_scalar_div: directed operations with hand-computed
// quotients; a driver issues operations and queues the expected response,
// a monitor pops and compares whenever done is seen.
module tb_matrix_scalar_div;
  import matrix_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [7:0]   data;
  logic [199:0] matrix_a;
  logic [199:0] result;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [1:0]   dbg_state;

  matrix_scalar_div dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .data        (data),
    .matrix_a    (matrix_a),
    .result      (result),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [199:0] res;
    logic         dbz;
    logic [31:0]  cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [199:0] act,
                       input logic [199:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [199:0] fill(input logic [7:0] v);
    logic [199:0] m;
    for (int i = 0; i < 25; i++) m[i*8 +: 8] = v;
    return m;
  endfunction

  // Monitor: every done pulse must match the oldest queued operation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 want no pending op");
      end else begin
        mon_e = exp_q.pop_front();
        check("result", result, mon_e.res);
        check("div_by_zero", 200'(div_by_zero), 200'(mon_e.dbz));
        check("done_cycle", 200'(cyc), 200'(mon_e.cyc));
        check("busy_at_done", 200'(busy), 200'(0));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_op(input logic [199:0] m, input logic [7:0] d,
                          input logic [199:0] exp_res, input logic exp_dbz,
                          input bit push);
    exp_t e;
    @(negedge clk);
    matrix_a = m;
    data     = d;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) begin
      e.res = exp_res;
      e.dbz = exp_dbz;
      e.cyc = 32'(cyc + ((d == 8'd0) ? 0 : 200));
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", 200'(n < 300), 200'(1));
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  logic [199:0] m2, e2, m4, e4;
  int t2_exp[25] = '{0, 1, 2, 4, 5, 7, 8, 10, 11, 12, 14, 15, 17, 18, 20,
                     21, 22, 24, 25, 27, 28, 30, 31, 32, 34};

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    data     = 8'd0;
    matrix_a = '0;
    #1;
    check("reset_result", result, 200'(0));
    check("reset_busy", 200'(busy), 200'(0));
    check("reset_done", 200'(done), 200'(0));
    check("reset_dbz", 200'(div_by_zero), 200'(0));
    check("reset_state", 200'(dbg_state), 200'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 1: uniform 200 / 10
    start_op(fill(8'd200), 8'd10, fill(8'd20), 1'b0, 1'b1);
    wait_done();

    // 2: ramp 10*i / 7
    for (int i = 0; i < 25; i++) begin
      m2[i*8 +: 8] = 8'(10 * i);
      e2[i*8 +: 8] = 8'(t2_exp[i]);
    end
    start_op(m2, 8'd7, e2, 1'b0, 1'b1);
    wait_done();

    // 3: divide by zero, then divide by one clears the flag
    start_op(m2, 8'd0, fill(8'hFF), 1'b1, 1'b1);
    wait_done();
    start_op(m2, 8'd1, m2, 1'b0, 1'b1);
    wait_done();

    // 4: width boundaries
    for (int i = 0; i < 25; i++) begin
      m4[i*8 +: 8] = (i % 2 == 0) ? 8'd255 : 8'd254;
      e4[i*8 +: 8] = (i % 2 == 0) ? 8'd1 : 8'd0;
    end
    start_op(m4, 8'd255, e4, 1'b0, 1'b1);
    wait_done();
    start_op(fill(8'hFF), 8'd1, fill(8'hFF), 1'b0, 1'b1);
    wait_done();

    // 5: operand changes and a second start mid-operation are ignored
    start_op(fill(8'd123), 8'd5, fill(8'd24), 1'b0, 1'b1);
    repeat (50) @(negedge clk);
    matrix_a = fill(8'd0);
    data     = 8'd3;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    wait_done();

    // 6: asynchronous reset mid-operation, then a clean operation
    start_op(fill(8'd77), 8'd9, '0, 1'b0, 1'b0);
    repeat (100) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midop_reset_busy", 200'(busy), 200'(0));
    check("midop_reset_done", 200'(done), 200'(0));
    check("midop_reset_result", result, 200'(0));
    check("midop_reset_dbz", 200'(div_by_zero), 200'(0));
    check("midop_reset_state", 200'(dbg_state), 200'(0));
    @(negedge clk);
    rst = 1'b0;
    start_op(fill(8'd100), 8'd3, fill(8'd33), 1'b0, 1'b1);
    wait_done();

    repeat (5) @(negedge clk);
    check("queue_empty", 200'(exp_q.size()), 200'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
